// File: rtl/sonic_dist_filter.sv
// Ultrasonic distance filter: periodic sampling, range rejection, 4-sample moving average,
// and a hysteretic, fail-safe stop flag.
module sonic_dist_filter #(
   parameter int unsigned SAMPLE_PERIOD = 10_000_000,
   parameter int unsigned NEAR_TH       = 4000,
   parameter int unsigned FAR_TH        = 5000,
   parameter int unsigned MAX_DIS       = 400000,
   parameter int unsigned FAULT_LIMIT   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] dis,
   output logic        sample_tick,
   output logic [19:0] avg_dis,
   output logic        stop,
   output logic        fault
);

   localparam int unsigned CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned IW = $clog2(FAULT_LIMIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);
   localparam logic [IW-1:0] INV_MAX  = IW'(FAULT_LIMIT);

   typedef enum logic [1:0] {StFill, StRun, StFault} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [3:0][19:0]  win_q, win_d;
   logic [21:0]       sum_q, sum_d;
   logic [2:0]        vcnt_q, vcnt_d;
   logic [IW-1:0]     icnt_q, icnt_d;
   logic              upd_q, upd_d;
   logic [19:0]       avg_q;
   logic              stop_q;
   logic              tick;
   logic              valid;
   logic [19:0]       avg_new;

   assign tick    = (cnt_q == CNT_LAST);
   assign valid   = (dis != 20'd0) && (32'(dis) <= MAX_DIS);
   assign avg_new = sum_q[21:2];

   assign sample_tick = tick;
   assign avg_dis     = avg_q;
   assign stop        = stop_q;
   assign fault       = (state_q == StFault);

   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      sum_d   = sum_q;
      vcnt_d  = vcnt_q;
      icnt_d  = icnt_q;
      upd_d   = 1'b0;
      if (tick) begin
         if (valid) begin
            icnt_d = '0;
            if (state_q == StFault) begin
               // Recovery restarts the window with this sample as its only entry.
               win_d   = {20'd0, 20'd0, 20'd0, dis};
               sum_d   = 22'(dis);
               vcnt_d  = 3'd1;
               state_d = StFill;
            end else begin
               win_d = {win_q[2:0], dis};
               sum_d = sum_q + 22'(dis) - 22'(win_q[3]);
               if (state_q == StFill) begin
                  vcnt_d = vcnt_q + 3'd1;
                  if (vcnt_q == 3'd3) begin
                     state_d = StRun;
                     upd_d   = 1'b1;
                  end
               end else begin
                  upd_d = 1'b1;
               end
            end
         end else begin
            if (icnt_q != INV_MAX) begin
               icnt_d = icnt_q + 1'b1;
            end
            if ((icnt_d == INV_MAX) && (state_q != StFault)) begin
               state_d = StFault;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFill;
         cnt_q   <= '0;
         win_q   <= '0;
         sum_q   <= '0;
         vcnt_q  <= '0;
         icnt_q  <= '0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         sum_q   <= sum_d;
         vcnt_q  <= vcnt_d;
         icnt_q  <= icnt_d;
         upd_q   <= upd_d;
      end
   end

   // Output stage runs one edge behind the window so it sees the freshly updated sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         avg_q  <= '0;
         stop_q <= 1'b1;
      end else if (upd_q) begin
         avg_q <= avg_new;
         if (32'(avg_new) < NEAR_TH) begin
            stop_q <= 1'b1;
         end else if (32'(avg_new) >= FAR_TH) begin
            stop_q <= 1'b0;
         end
      end else if (state_q != StRun) begin
         stop_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sonic_dist_filter.sv
// Self-checking bench for sonic_dist_filter: directed vector table, reset sequence,
// and randomized samples against a queue-based reference model.
module tb_sonic_dist_filter;

   localparam int unsigned SP   = 10;
   localparam int unsigned NEAR = 4000;
   localparam int unsigned FAR  = 5000;
   localparam int unsigned MAXD = 400000;
   localparam int unsigned LIM  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] dis = '0;
   logic        sample_tick;
   logic [19:0] avg_dis;
   logic        stop;
   logic        fault;

   int checks   = 0;
   int failures = 0;

   sonic_dist_filter #(
      .SAMPLE_PERIOD(SP),
      .NEAR_TH(NEAR),
      .FAR_TH(FAR),
      .MAX_DIS(MAXD),
      .FAULT_LIMIT(LIM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .dis(dis),
      .sample_tick(sample_tick),
      .avg_dis(avg_dis),
      .stop(stop),
      .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned d;
      int unsigned avg;
      bit          stp;
      bit          flt;
   } vec_t;

   vec_t tv[$];

   // Reference model: window of valid samples as a queue, mode 0=fill 1=run 2=fault.
   int unsigned mwin[$];
   int          mmode;
   int          minv;
   int unsigned mavg;
   bit          mstop;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input int unsigned d, input int unsigned a, input bit s, input bit f);
      vec_t v;
      v.d   = d;
      v.avg = a;
      v.stp = s;
      v.flt = f;
      tv.push_back(v);
   endtask

   task automatic model_reset();
      mwin.delete();
      mmode = 0;
      minv  = 0;
      mavg  = 0;
      mstop = 1;
   endtask

   task automatic model_sample(input int unsigned v);
      int unsigned s;
      if (v != 0 && v <= MAXD) begin
         minv = 0;
         if (mmode == 2) begin
            mwin.delete();
            mwin.push_back(v);
            mmode = 0;
         end else begin
            mwin.push_back(v);
            if (mwin.size() > 4) void'(mwin.pop_front());
            if (mmode == 0 && mwin.size() == 4) mmode = 1;
            if (mmode == 1) begin
               s = 0;
               foreach (mwin[i]) s += mwin[i];
               mavg = s / 4;
               if (mavg < NEAR) mstop = 1;
               else if (mavg >= FAR) mstop = 0;
            end
         end
      end else begin
         if (minv < LIM) minv++;
         if (minv == LIM && mmode != 2) mmode = 2;
      end
      if (mmode != 1) mstop = 1;
   endtask

   task automatic wait_tick(output bit ok);
      int n = 0;
      ok = 1'b1;
      while (!sample_tick) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 4 * SP) begin
            ok = 1'b0;
            checks++;
            failures++;
            $display("FAIL tick_timeout: actual=no tick required=tick within %0d cycles", 4 * SP);
            break;
         end
      end
   endtask

   // Drive one sample through a tick; returns once the registered outputs reflect it.
   task automatic do_sample(input int unsigned v, output bit ok);
      dis = 20'(v);
      wait_tick(ok);
      if (ok) begin
         repeat (3) @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      bit ok;
      int n;
      int unsigned v;
      int r;

      // Directed vectors from the behavioural scenarios.
      repeat (3) add_vec(10000, 0, 1, 0);
      add_vec(10000, 10000, 0, 0);
      add_vec(3000, 8250, 0, 0);
      add_vec(3000, 6500, 0, 0);
      add_vec(3000, 4750, 0, 0);
      add_vec(3000, 3000, 1, 0);
      add_vec(4500, 3375, 1, 0);
      add_vec(4500, 3750, 1, 0);
      add_vec(4500, 4125, 1, 0);
      add_vec(4500, 4500, 1, 0);
      add_vec(5000, 4625, 1, 0);
      add_vec(5000, 4750, 1, 0);
      add_vec(5000, 4875, 1, 0);
      add_vec(5000, 5000, 0, 0);
      repeat (7) add_vec(0, 5000, 0, 0);
      add_vec(5000, 5000, 0, 0);
      repeat (7) add_vec(500000, 5000, 0, 0);
      add_vec(500000, 5000, 1, 1);
      add_vec(9000, 5000, 1, 0);
      add_vec(9000, 5000, 1, 0);
      add_vec(9000, 5000, 1, 0);
      add_vec(9000, 9000, 0, 0);
      add_vec(400000, 106750, 0, 0);
      add_vec(400001, 106750, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_avg", avg_dis, 0);
      check("reset_stop", stop, 1);
      check("reset_fault", fault, 0);
      check("reset_tick", sample_tick, 0);

      for (int i = 0; i < tv.size(); i++) begin
         do_sample(tv[i].d, ok);
         if (!ok) break;
         check($sformatf("vec%0d_avg", i), avg_dis, tv[i].avg);
         check($sformatf("vec%0d_stop", i), stop, tv[i].stp);
         check($sformatf("vec%0d_fault", i), fault, tv[i].flt);
      end

      // Reset mid-RUN: everything cleared, next tick 10 cycles after the reset edge.
      do_sample(10000, ok);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_avg", avg_dis, 0);
      check("midrst_stop", stop, 1);
      check("midrst_fault", fault, 0);
      check("midrst_tick", sample_tick, 0);
      n = 1;
      while (!sample_tick && n < 4 * SP) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("midrst_tick_delay", n, SP);

      // Randomized phase against the reference model.
      do_reset();
      model_reset();
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 11);
         case (r)
            0: v = 0;
            1: v = $urandom_range(400001, 1048575);
            2: v = MAXD;
            3: v = NEAR;
            4: v = FAR;
            default: v = $urandom_range(3000, 6000);
         endcase
         if (r == 11) begin
            repeat (LIM) begin
               do_sample(0, ok);
               if (!ok) break;
               model_sample(0);
            end
            if (!ok) break;
         end
         do_sample(v, ok);
         if (!ok) break;
         model_sample(v);
         check($sformatf("rnd%0d_avg", i), avg_dis, mavg);
         check($sformatf("rnd%0d_stop", i), stop, mstop);
         check($sformatf("rnd%0d_fault", i), fault, (mmode == 2) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
